// File: rtl/psg_bus_sequencer.sv
// Command-queued bus master for an AY-3-8912-style PSG: sequences BDIR/BC1/DA7-0 through
// address-latch, write and read cycles with inactive gaps, returning read data as a one-clock pulse.
module psg_bus_sequencer #(
    parameter int HOLD       = 2,
    parameter int DEPTH_LOG2 = 3,
    parameter int ELIDE_ADDR = 1
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic                  ce,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [3:0]            cmd_addr,
    input  logic [7:0]            cmd_data,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  bdir,
    output logic                  bc1,
    output logic [7:0]            d,
    output logic                  d_oe,
    input  logic [7:0]            q,
    output logic [2:0]            state_dbg
);
    // Handshake: a command is pushed on any clock where cmd_valid && cmd_ready, regardless of ce.
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP1 = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_GAP2 = 3'd5
    } state_t;

    logic [12:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty, full, push, pop;
    logic                  head_rw;
    logic [3:0]            head_addr;
    logic [7:0]            head_data;

    assign empty      = (count == '0);
    assign full       = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign push       = cmd_valid && !full;
    assign cmd_ready  = !full;
    assign fifo_level = count;
    assign head_rw    = mem[rd_ptr][12];
    assign head_addr  = mem[rd_ptr][11:8];
    assign head_data  = mem[rd_ptr][7:0];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    state_t          state, state_next, start_state;
    logic [PW-1:0]   phase;
    logic            phase_last, elide;
    logic            cur_rw;
    logic [3:0]      cur_addr, lat_addr, addr_n;
    logic [7:0]      cur_data, data_n;
    logic            lat_valid;
    logic            bdir_n, bc1_n, d_oe_n;
    logic [7:0]      d_n;

    assign phase_last  = (phase == PW'(HOLD - 1));
    assign elide       = (ELIDE_ADDR != 0) && lat_valid && (head_addr == lat_addr);
    assign start_state = elide ? (head_rw ? S_RD : S_WR) : S_ADDR;
    assign busy        = (state != S_IDLE) || !empty;
    assign state_dbg   = state;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (ce) begin
            case (state)
                S_IDLE: if (!empty) begin
                    pop        = 1'b1;
                    state_next = start_state;
                end
                S_ADDR: if (phase_last) state_next = S_GAP1;
                S_GAP1: if (phase_last) state_next = cur_rw ? S_RD : S_WR;
                S_WR, S_RD: if (phase_last) state_next = S_GAP2;
                S_GAP2: if (phase_last) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = start_state;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Bus outputs are computed for the state being entered so they register with it.
    always_comb begin
        addr_n = pop ? head_addr : cur_addr;
        data_n = pop ? head_data : cur_data;
        bdir_n = 1'b0;
        bc1_n  = 1'b0;
        d_n    = 8'h00;
        d_oe_n = 1'b0;
        case (state_next)
            S_ADDR: begin
                bdir_n = 1'b1;
                bc1_n  = 1'b1;
                d_n    = {4'b0000, addr_n};
                d_oe_n = 1'b1;
            end
            S_WR: begin
                bdir_n = 1'b1;
                d_n    = data_n;
                d_oe_n = 1'b1;
            end
            S_RD:    bc1_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase     <= '0;
            cur_rw    <= 1'b0;
            cur_addr  <= 4'h0;
            cur_data  <= 8'h00;
            lat_addr  <= 4'h0;
            lat_valid <= 1'b0;
            bdir      <= 1'b0;
            bc1       <= 1'b0;
            d         <= 8'h00;
            d_oe      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state <= state_next;
            bdir  <= bdir_n;
            bc1   <= bc1_n;
            d     <= d_n;
            d_oe  <= d_oe_n;
            if (ce && state != S_IDLE) phase <= phase_last ? '0 : phase + PW'(1);
            if (pop) begin
                cur_rw   <= head_rw;
                cur_addr <= head_addr;
                cur_data <= head_data;
            end
            if (ce && state == S_ADDR && phase_last) begin
                lat_addr  <= cur_addr;
                lat_valid <= 1'b1;
            end
            rsp_valid <= ce && state == S_RD && phase_last;
            if (ce && state == S_RD && phase_last) rsp_data <= q;
        end
    end
endmodule
